logic_response_checker: RTL and testbench

//   Self-checking counterpart to a combinational logic-function DUT.
//   - Sweeps every N_IN-bit input vector onto the DUT and samples its output after a settle window.
//   - Assembles the observed truth table and compares it with an expected table at the end of the sweep.
//   - Sits on the bench or FPGA top, replacing free-running toggle stimulus with clocked, checked sweeps.

---
 rtl/logic_chk_pkg.sv | 13 +
 rtl/logic_response_checker_settle_timer.sv | 29 ++
 rtl/logic_response_checker.sv | 144 ++++++++++++++
 tb/tb_logic_response_checker.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_chk_pkg.sv
// Shared types and defaults for the logic response checker.
//   chk_state_t : sweep FSM states
//   N_IN_DEF, SETTLE_CYC_DEF, MAJ3_TT : default geometry and the
//   3-input majority truth table used as the default expectation.
package logic_chk_pkg;

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} chk_state_t;

  localparam int          N_IN_DEF       = 3;
  localparam int          SETTLE_CYC_DEF = 4;
  localparam logic [7:0]  MAJ3_TT        = 8'hE8;

endpackage

// File: rtl/logic_response_checker_settle_timer.sv
// settle_timer: down-counter that holds each vector for SETTLE_CYC cycles.
//   clk, rst_n : clock, async active-low reset (count resets to 0)
//   i_load     : reload with SETTLE_CYC-1
//   i_dec      : decrement (stops at 0)
//   o_zero     : count is 0
module settle_timer #(
  parameter int SETTLE_CYC = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_load,
  input  logic i_dec,
  output logic o_zero
);

  // Keep at least one bit so SETTLE_CYC==1 still elaborates.
  localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       r_cnt <= '0;
    else if (i_load)                  r_cnt <= CW'(SETTLE_CYC - 1);
    else if (i_dec && r_cnt != '0)    r_cnt <= r_cnt - 1'b1;
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/logic_response_checker.sv
// logic_response_checker: sweeps all 2**N_IN input vectors onto a
// combinational DUT, samples F after a settle window, builds the observed
// truth table and compares it with EXP_TT when the sweep completes.
//   clk, rst_n : clock, async active-low reset
//   start      : sweep request, sampled only in IDLE
//   f_i        : DUT output F (sampled raw; DUT is combinational from vec_o)
//   vec_o      : registered DUT input vector
//   busy       : sweep in progress
//   done       : one-cycle completion pulse
//   pass       : obs_tt == EXP_TT, valid from done to next accepted start
//   obs_tt     : observed truth table
//   fail_idx   : lowest mismatching vector   (MISMATCH_LOG_EN only)
//   fail_valid : a mismatch was recorded     (MISMATCH_LOG_EN only)
// Optional feature macro: MISMATCH_LOG_EN (undefined: fail_* tied to 0).
module logic_response_checker
  import logic_chk_pkg::*;
#(
  parameter int                 N_IN       = N_IN_DEF,
  parameter int                 SETTLE_CYC = SETTLE_CYC_DEF,
  parameter logic [2**N_IN-1:0] EXP_TT     = (2**N_IN)'(MAJ3_TT)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 f_i,
  output logic [N_IN-1:0]      vec_o,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [2**N_IN-1:0]   obs_tt,
  output logic [N_IN-1:0]      fail_idx,
  output logic                 fail_valid
);

  chk_state_t            r_state, w_nxt;
  logic [N_IN-1:0]       r_vec;
  logic [2**N_IN-1:0]    r_obs;
  logic                  r_busy, r_done, r_pass;
  logic                  w_accept, w_load, w_dec, w_sample, w_zero, w_last;

  assign w_last = (r_vec == '1);

  settle_timer #(.SETTLE_CYC(SETTLE_CYC)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_load),
    .i_dec  (w_dec),
    .o_zero (w_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nxt;
  end

  always_comb begin
    w_nxt    = r_state;
    w_accept = 1'b0;
    w_load   = 1'b0;
    w_dec    = 1'b0;
    w_sample = 1'b0;
    case (r_state)
      IDLE:   if (start) begin
                w_accept = 1'b1;
                w_load   = 1'b1;
                w_nxt    = SETTLE;
              end
      SETTLE: if (w_zero) w_nxt = SAMPLE;
              else        w_dec = 1'b1;
      SAMPLE: begin
                w_sample = 1'b1;
                if (w_last) w_nxt = DONE;
                else begin
                  w_load = 1'b1;
                  w_nxt  = SETTLE;
                end
              end
      DONE:   w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
  end

  // Vector, table capture and status flags. vec_o deliberately stops at the
  // last vector; obs_tt/pass/vec_o hold in IDLE until the next start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vec  <= '0;
      r_obs  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_pass <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_vec  <= '0;
        r_obs  <= '0;
        r_pass <= 1'b0;
        r_busy <= 1'b1;
      end
      if (w_sample) begin
        r_obs[r_vec] <= f_i;
        if (!w_last) r_vec <= r_vec + 1'b1;
      end
      // In DONE the last sampled bit is already in r_obs.
      if (r_state == DONE) begin
        r_done <= 1'b1;
        r_pass <= (r_obs == EXP_TT);
        r_busy <= 1'b0;
      end
    end
  end

`ifdef MISMATCH_LOG_EN
  logic [N_IN-1:0] r_fail_idx;
  logic            r_fail_valid;

  // Vectors are swept in ascending order, so the first mismatch is the lowest.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fail_idx   <= '0;
      r_fail_valid <= 1'b0;
    end else if (w_accept) begin
      r_fail_idx   <= '0;
      r_fail_valid <= 1'b0;
    end else if (w_sample && (f_i != EXP_TT[r_vec]) && !r_fail_valid) begin
      r_fail_idx   <= r_vec;
      r_fail_valid <= 1'b1;
    end
  end

  assign fail_idx   = r_fail_idx;
  assign fail_valid = r_fail_valid;
`else
  assign fail_idx   = '0;
  assign fail_valid = 1'b0;
`endif

  assign vec_o  = r_vec;
  assign busy   = r_busy;
  assign done   = r_done;
  assign pass   = r_pass;
  assign obs_tt = r_obs;

endmodule

// File: tb/tb_logic_response_checker.sv
// Bench for logic_response_checker: two instances (SETTLE_CYC=4 and 1)
// driven by a table-lookup "DUT" whose truth table the bench chooses.
// A timeline model predicts every output from the accept cycle.
module tb_logic_response_checker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] tbl = 8'hE8;
  logic [7:0] exp_v = 8'hE8;

  logic [2:0] vec0, vec1, fidx0, fidx1;
  logic       busy0, busy1, done0, done1, pass0, pass1, fval0, fval1, f0, f1;
  logic [7:0] obs0, obs1;

  int nchk = 0;
  int nerr = 0;

  assign f0 = tbl[vec0];
  assign f1 = tbl[vec1];

  always #5 clk = ~clk;

  logic_response_checker #(.N_IN(3), .SETTLE_CYC(4), .EXP_TT(8'hE8)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start), .f_i(f0), .vec_o(vec0),
    .busy(busy0), .done(done0), .pass(pass0), .obs_tt(obs0),
    .fail_idx(fidx0), .fail_valid(fval0));

  logic_response_checker #(.N_IN(3), .SETTLE_CYC(1), .EXP_TT(8'hE8)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start), .f_i(f1), .vec_o(vec1),
    .busy(busy1), .done(done1), .pass(pass1), .obs_tt(obs1),
    .fail_idx(fidx1), .fail_valid(fval1));

  // ---------------- model state ----------------
  int         cyc;
  bit         have [2];
  int         acc  [2];
  logic [7:0] mtbl [2];
  int         sp   [2] = '{5, 2};   // cycles per vector = SETTLE_CYC+1

  function automatic int tdone(input int i);
    return 8 * sp[i] + 1;
  endfunction

  // A sweep is accepted on an edge where the instance is idle: never
  // started, or strictly after its DONE->IDLE edge (acc + tdone).
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc  <= 0;
      have <= '{1'b0, 1'b0};
    end else begin
      cyc <= cyc + 1;
      for (int i = 0; i < 2; i++)
        if (start && (!have[i] || (cyc + 1 - acc[i]) >= tdone(i) + 1)) begin
          have[i] <= 1'b1;
          acc[i]  <= cyc + 1;
          mtbl[i] <= tbl;
        end
    end
  end

  task automatic model(input int i, output logic [2:0] ev, output logic [7:0] eo,
                       output logic eb, output logic ed, output logic ep,
                       output logic fv, output logic [2:0] fi);
    int k, v;
    ev = '0; eo = '0; eb = 0; ed = 0; ep = 0; fv = 0; fi = '0;
    if (have[i]) begin
      k  = cyc - acc[i];
      eb = (k < tdone(i));
      ed = (k == tdone(i));
      v  = k / sp[i];
      ev = 3'((v > 7) ? 7 : v);
      for (int j = 0; j < 8; j++)
        if (sp[i] * (j + 1) <= k) begin
          eo[j] = mtbl[i][j];
          if (mtbl[i][j] != exp_v[j] && !fv) begin
            fv = 1'b1;
            fi = 3'(j);
          end
        end
      ep = (k >= tdone(i)) && (mtbl[i] == exp_v);
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    nchk++;
    if (act !== expv) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, expv, $time);
    end
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    logic [2:0] ev, fi;
    logic [7:0] eo;
    logic eb, ed, ep, fv;
    model(0, ev, eo, eb, ed, ep, fv, fi);
    chk("u0.vec",  32'(vec0),  32'(ev));
    chk("u0.obs",  32'(obs0),  32'(eo));
    chk("u0.busy", 32'(busy0), 32'(eb));
    chk("u0.done", 32'(done0), 32'(ed));
    chk("u0.pass", 32'(pass0), 32'(ep));
`ifdef MISMATCH_LOG_EN
    chk("u0.fval", 32'(fval0), 32'(fv));
    chk("u0.fidx", 32'(fidx0), 32'(fi));
`else
    chk("u0.fval", 32'(fval0), 32'd0);
    chk("u0.fidx", 32'(fidx0), 32'd0);
`endif
    model(1, ev, eo, eb, ed, ep, fv, fi);
    chk("u1.vec",  32'(vec1),  32'(ev));
    chk("u1.obs",  32'(obs1),  32'(eo));
    chk("u1.busy", 32'(busy1), 32'(eb));
    chk("u1.done", 32'(done1), 32'(ed));
    chk("u1.pass", 32'(pass1), 32'(ep));
`ifdef MISMATCH_LOG_EN
    chk("u1.fval", 32'(fval1), 32'(fv));
    chk("u1.fidx", 32'(fidx1), 32'(fi));
`else
    chk("u1.fval", 32'(fval1), 32'd0);
    chk("u1.fidx", 32'(fidx1), 32'd0);
`endif
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_idle();
    int n = 0;
    while ((busy0 || busy1 || done0 || done1 || start) && n < 300) begin
      start = 1'b0;
      @(negedge clk);
      n++;
    end
    if (n >= 300) chk("idle_timeout", 32'd0, 32'd1);
  endtask

  // Start one sweep with table t; report cycles from accept to done on
  // each instance, and u0's results at its done pulse.
  task automatic sweep(input logic [7:0] t, input bit rnd, output int n0, output int n1,
                       output logic [7:0] o0, output logic p0,
                       output logic v0, output logic [2:0] i0);
    int n = 0;
    wait_idle();
    tbl = t;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n0 = -1; n1 = -1; o0 = '0; p0 = 0; v0 = 0; i0 = '0;
    while ((n0 < 0 || n1 < 0) && n < 200) begin
      if (done0 && n0 < 0) begin n0 = n; o0 = obs0; p0 = pass0; v0 = fval0; i0 = fidx0; end
      if (done1 && n1 < 0) n1 = n;
      if (n0 < 0 || n1 < 0) begin
        start = rnd && (n > 0) && (n < 36) && ($urandom % 6 == 0);
        @(negedge clk);
        n++;
      end
    end
    start = 1'b0;
    if (n >= 200) chk("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int n0, n1, n;
    logic [7:0] o0;
    logic p0, v0;
    logic [2:0] i0;

    // 1: reset with start held high
    rst_n = 1'b0; start = 1'b1;
    repeat (5) @(negedge clk);
    chk("t1_busy_in_reset", 32'(busy0), 32'd0);
    chk("t1_obs_in_reset",  32'(obs0),  32'd0);
    start = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("t1_no_sweep", 32'(busy0 | busy1), 32'd0);

    // 2: majority function
    sweep(8'hE8, 1'b0, n0, n1, o0, p0, v0, i0);
    chk("t2_lat0", 32'(n0), 32'd41);
    chk("t2_lat1", 32'(n1), 32'd17);
    chk("t2_obs",  32'(o0), 32'hE8);
    chk("t2_pass", 32'(p0), 32'd1);
    chk("t2_fval", 32'(v0), 32'd0);

    // 3: vec0 forced 1, vec6 inverted
    sweep(8'hA9, 1'b0, n0, n1, o0, p0, v0, i0);
    chk("t3_obs",  32'(o0), 32'hA9);
    chk("t3_pass", 32'(p0), 32'd0);
`ifdef MISMATCH_LOG_EN
    chk("t3_fval", 32'(v0), 32'd1);
    chk("t3_fidx", 32'(i0), 32'd0);
`else
    chk("t3_fval", 32'(v0), 32'd0);
`endif

    // 4: start mid-sweep ignored, then start held across DONE
    wait_idle();
    tbl = 8'hE8;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0; n0 = -1;
    while (n < 60 && n0 < 0) begin
      if (done0) n0 = n;
      else begin
        start = (n == 10) || (n >= 35);
        @(negedge clk);
        n++;
      end
    end
    chk("t4_lat0", 32'(n0), 32'd41);
    @(negedge clk);
    chk("t4_restart_busy", 32'(busy0), 32'd1);
    chk("t4_restart_vec",  32'(vec0),  32'd0);
    start = 1'b0;

    // 5: reset during vector 3
    wait_idle();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (vec0 != 3'd3 && n < 100) begin @(negedge clk); n++; end
    chk("t5_reach_vec3", 32'(vec0), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_busy_clr", 32'(busy0), 32'd0);
    chk("t5_vec_clr",  32'(vec0),  32'd0);
    chk("t5_obs_clr",  32'(obs0),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    sweep(8'hE8, 1'b0, n0, n1, o0, p0, v0, i0);
    chk("t5_lat0", 32'(n0), 32'd41);
    chk("t5_pass", 32'(p0), 32'd1);

    // random tables with stray start pulses
    for (int r = 0; r < 12; r++) begin
      logic [7:0] t;
      t = ($urandom % 3 == 0) ? 8'hE8 : 8'($urandom);
      sweep(t, 1'b1, n0, n1, o0, p0, v0, i0);
      chk("rnd_lat0", 32'(n0), 32'd41);
      chk("rnd_obs",  32'(o0), 32'(t));
    end

    wait_idle();
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", nerr);
    $fatal(1, "watchdog");
  end

endmodule
